// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//   Wakeup-and-select controller for a reservation station (RS). Each entry
//   holds a valid bit, a target FU, two source tags with ready bits and one
//   row of an age matrix. Completion broadcasts (cdb) wake waiting operands.
//   Every cycle the oldest ready entry for each FU is offered over a
//   valid/ready handshake. The entry is freed when the handshake completes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous clear of all entries
//   alloc_*_1 / alloc_*_2      two dispatch slots. Slot 1 is older.
//   cdb_valid_k / cdb_preg_k   completion broadcast from FU k (k = 0..2)
//   fu_ready_k                 FU k accepts an issue this cycle
//   issue_valid_k / issue_idx_k  entry offered to FU k (idx is 0 when idle)
//   rs_free / free_count       bitmap and popcount of unused entries
//   alloc_err                  sticky illegal-allocation flag
// -----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        alloc_valid_1,
  input  logic                        alloc_valid_2,
  input  logic [$clog2(RS_DEPTH)-1:0] alloc_idx_1,
  input  logic [$clog2(RS_DEPTH)-1:0] alloc_idx_2,
  input  logic [1:0]                  alloc_fu_1,
  input  logic [1:0]                  alloc_fu_2,
  input  logic [PREG_W-1:0]           alloc_ps1_1,
  input  logic [PREG_W-1:0]           alloc_ps2_1,
  input  logic [PREG_W-1:0]           alloc_ps1_2,
  input  logic [PREG_W-1:0]           alloc_ps2_2,
  input  logic                        alloc_rdy1_1,
  input  logic                        alloc_rdy2_1,
  input  logic                        alloc_rdy1_2,
  input  logic                        alloc_rdy2_2,
  input  logic                        cdb_valid_0,
  input  logic                        cdb_valid_1,
  input  logic                        cdb_valid_2,
  input  logic [PREG_W-1:0]           cdb_preg_0,
  input  logic [PREG_W-1:0]           cdb_preg_1,
  input  logic [PREG_W-1:0]           cdb_preg_2,
  input  logic                        fu_ready_0,
  input  logic                        fu_ready_1,
  input  logic                        fu_ready_2,
  output logic                        issue_valid_0,
  output logic                        issue_valid_1,
  output logic                        issue_valid_2,
  output logic [$clog2(RS_DEPTH)-1:0] issue_idx_0,
  output logic [$clog2(RS_DEPTH)-1:0] issue_idx_1,
  output logic [$clog2(RS_DEPTH)-1:0] issue_idx_2,
  output logic [RS_DEPTH-1:0]         rs_free,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_count,
  output logic                        alloc_err
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);
  localparam int N_FU  = 3;

  // Registered state
  logic [RS_DEPTH-1:0] r_valid;
  logic [RS_DEPTH-1:0] r_rdy1;
  logic [RS_DEPTH-1:0] r_rdy2;
  logic [1:0]          r_fu    [RS_DEPTH];
  logic [PREG_W-1:0]   r_ps1   [RS_DEPTH];
  logic [PREG_W-1:0]   r_ps2   [RS_DEPTH];
  logic [RS_DEPTH-1:0] r_older [RS_DEPTH];  // r_older[i][j]: i allocated before j
  logic                r_alloc_err;

  // Input bundling
  logic [N_FU-1:0]     w_cdb_valid;
  logic [PREG_W-1:0]   w_cdb_preg [N_FU];
  logic [N_FU-1:0]     w_fu_ready;

  assign w_cdb_valid   = {cdb_valid_2, cdb_valid_1, cdb_valid_0};
  assign w_cdb_preg[0] = cdb_preg_0;
  assign w_cdb_preg[1] = cdb_preg_1;
  assign w_cdb_preg[2] = cdb_preg_2;
  assign w_fu_ready    = {fu_ready_2, fu_ready_1, fu_ready_0};

  // True when any broadcasting FU writes the given tag this cycle.
  function automatic logic f_wake(input logic [PREG_W-1:0] tag,
                                  input logic [N_FU-1:0]   cv,
                                  input logic [PREG_W-1:0] p0,
                                  input logic [PREG_W-1:0] p1,
                                  input logic [PREG_W-1:0] p2);
    f_wake = (cv[0] && (p0 == tag)) || (cv[1] && (p1 == tag)) ||
             (cv[2] && (p2 == tag));
  endfunction

  // ---------------------------------------------------------------------------
  // Select: built from registered state only.
  // ---------------------------------------------------------------------------
  logic [RS_DEPTH-1:0] w_elig  [N_FU];
  logic [RS_DEPTH-1:0] w_col   [RS_DEPTH];  // w_col[i][j] = r_older[j][i]
  logic [N_FU-1:0]     w_iss_valid;
  logic [IDX_W-1:0]    w_iss_idx [N_FU];

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        w_col[i][j] = r_older[j][i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_FU; k++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_elig[k][i] = r_valid[i] && r_rdy1[i] && r_rdy2[i] && (r_fu[i] == 2'(k));
      end
    end
  end

  // An entry wins when no other eligible entry for the same FU is older.
  // The age matrix is a strict order, so at most one entry can win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    w_iss_valid = '0;
    for (int k = 0; k < N_FU; k++) begin
      w_iss_idx[k] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_elig[k][i] && !w_iss_valid[k] && ((w_col[i] & w_elig[k]) == '0)) begin
          w_iss_valid[k] = 1'b1;
          w_iss_idx[k]   = IDX_W'(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer, allocation legality, wakeup and the next-state build
  // ---------------------------------------------------------------------------
  logic [RS_DEPTH-1:0] w_xfer;
  logic [RS_DEPTH-1:0] w_valid_post;
  logic                w_ok1, w_ok2, w_err_evt;
  logic [RS_DEPTH-1:0] w_valid_nxt, w_rdy1_nxt, w_rdy2_nxt;
  logic [1:0]          w_fu_nxt    [RS_DEPTH];
  logic [PREG_W-1:0]   w_ps1_nxt   [RS_DEPTH];
  logic [PREG_W-1:0]   w_ps2_nxt   [RS_DEPTH];
  logic [RS_DEPTH-1:0] w_older_nxt [RS_DEPTH];

  always_comb begin
    w_xfer = '0;
    for (int k = 0; k < N_FU; k++) begin
      if (w_iss_valid[k] && w_fu_ready[k]) w_xfer[w_iss_idx[k]] = 1'b1;
    end
  end

  assign w_valid_post = r_valid & ~w_xfer;

  // Legality is judged against the visible rs_free, so an index being
  // transferred on this same edge still counts as in use.
  assign w_ok1 = alloc_valid_1 && !r_valid[alloc_idx_1] && (alloc_fu_1 != 2'd3);
  assign w_ok2 = alloc_valid_2 && !r_valid[alloc_idx_2] && (alloc_fu_2 != 2'd3) &&
                 !(alloc_valid_1 && (alloc_idx_2 == alloc_idx_1));
  // Illegal requests are flagged even in a flush cycle; only the entry
  // update is discarded by flush.
  assign w_err_evt = (alloc_valid_1 && !w_ok1) || (alloc_valid_2 && !w_ok2);

  always_comb begin
    w_valid_nxt = w_valid_post;
    w_rdy1_nxt  = r_rdy1;
    w_rdy2_nxt  = r_rdy2;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_fu_nxt[i]    = r_fu[i];
      w_ps1_nxt[i]   = r_ps1[i];
      w_ps2_nxt[i]   = r_ps2[i];
      w_older_nxt[i] = r_older[i];
      if (r_valid[i] && f_wake(r_ps1[i], w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]))
        w_rdy1_nxt[i] = 1'b1;
      if (r_valid[i] && f_wake(r_ps2[i], w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]))
        w_rdy2_nxt[i] = 1'b1;
    end

    // Slot 1: younger than every entry surviving this edge.
    if (w_ok1) begin
      w_valid_nxt[alloc_idx_1] = 1'b1;
      w_fu_nxt[alloc_idx_1]    = alloc_fu_1;
      w_ps1_nxt[alloc_idx_1]   = alloc_ps1_1;
      w_ps2_nxt[alloc_idx_1]   = alloc_ps2_1;
      w_rdy1_nxt[alloc_idx_1]  = alloc_rdy1_1 ||
        f_wake(alloc_ps1_1, w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]);
      w_rdy2_nxt[alloc_idx_1]  = alloc_rdy2_1 ||
        f_wake(alloc_ps2_1, w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]);
      w_older_nxt[alloc_idx_1] = '0;
      for (int j = 0; j < RS_DEPTH; j++) w_older_nxt[j][alloc_idx_1] = w_valid_post[j];
    end

    // Slot 2: additionally younger than slot 1. Applied after slot 1 so the
    // older[slot1][slot2] bit survives the slot-1 row clear.
    if (w_ok2) begin
      w_valid_nxt[alloc_idx_2] = 1'b1;
      w_fu_nxt[alloc_idx_2]    = alloc_fu_2;
      w_ps1_nxt[alloc_idx_2]   = alloc_ps1_2;
      w_ps2_nxt[alloc_idx_2]   = alloc_ps2_2;
      w_rdy1_nxt[alloc_idx_2]  = alloc_rdy1_2 ||
        f_wake(alloc_ps1_2, w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]);
      w_rdy2_nxt[alloc_idx_2]  = alloc_rdy2_2 ||
        f_wake(alloc_ps2_2, w_cdb_valid, w_cdb_preg[0], w_cdb_preg[1], w_cdb_preg[2]);
      w_older_nxt[alloc_idx_2] = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        w_older_nxt[j][alloc_idx_2] = w_valid_post[j] || (w_ok1 && (alloc_idx_1 == IDX_W'(j)));
      end
    end

    if (flush) begin
      w_valid_nxt = '0;
      w_rdy1_nxt  = '0;
      w_rdy2_nxt  = '0;
      for (int i = 0; i < RS_DEPTH; i++) w_older_nxt[i] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_rdy1      <= '0;
      r_rdy2      <= '0;
      r_alloc_err <= 1'b0;
      // NOTE: the per-entry arrays are flops, not a RAM, so resetting them
      // costs little and keeps unknowns out of the select logic after reset.
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_fu[i]    <= '0;
        r_ps1[i]   <= '0;
        r_ps2[i]   <= '0;
        r_older[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values, independent of statement order.
      r_valid <= w_valid_nxt;
      r_rdy1  <= w_rdy1_nxt;
      r_rdy2  <= w_rdy2_nxt;
      if (w_err_evt) r_alloc_err <= 1'b1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_fu[i]    <= w_fu_nxt[i];
        r_ps1[i]   <= w_ps1_nxt[i];
        r_ps2[i]   <= w_ps2_nxt[i];
        r_older[i] <= w_older_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_free_count;

  always_comb begin
    w_free_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) w_free_count = w_free_count + CNT_W'(!r_valid[i]);
  end

  assign issue_valid_0 = w_iss_valid[0];
  assign issue_valid_1 = w_iss_valid[1];
  assign issue_valid_2 = w_iss_valid[2];
  assign issue_idx_0   = w_iss_idx[0];
  assign issue_idx_1   = w_iss_idx[1];
  assign issue_idx_2   = w_iss_idx[2];
  assign rs_free       = ~r_valid;
  assign free_count    = w_free_count;
  assign alloc_err     = r_alloc_err;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//   Self-checking bench for issue_scheduler. The reference model keeps each
//   entry with an allocation sequence number; the oldest eligible entry is the
//   one with the smallest number. Inputs change and outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;

  logic       clk, rst_n, flush;
  logic       alloc_valid_1, alloc_valid_2;
  logic [3:0] alloc_idx_1, alloc_idx_2;
  logic [1:0] alloc_fu_1, alloc_fu_2;
  logic [5:0] alloc_ps1_1, alloc_ps2_1, alloc_ps1_2, alloc_ps2_2;
  logic       alloc_rdy1_1, alloc_rdy2_1, alloc_rdy1_2, alloc_rdy2_2;
  logic       cdb_valid_0, cdb_valid_1, cdb_valid_2;
  logic [5:0] cdb_preg_0, cdb_preg_1, cdb_preg_2;
  logic       fu_ready_0, fu_ready_1, fu_ready_2;
  logic       issue_valid_0, issue_valid_1, issue_valid_2;
  logic [3:0] issue_idx_0, issue_idx_1, issue_idx_2;
  logic [15:0] rs_free;
  logic [4:0] free_count;
  logic       alloc_err;

  issue_scheduler #(.RS_DEPTH(16), .PREG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .alloc_fu_1(alloc_fu_1), .alloc_fu_2(alloc_fu_2),
    .alloc_ps1_1(alloc_ps1_1), .alloc_ps2_1(alloc_ps2_1),
    .alloc_ps1_2(alloc_ps1_2), .alloc_ps2_2(alloc_ps2_2),
    .alloc_rdy1_1(alloc_rdy1_1), .alloc_rdy2_1(alloc_rdy2_1),
    .alloc_rdy1_2(alloc_rdy1_2), .alloc_rdy2_2(alloc_rdy2_2),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1), .cdb_valid_2(cdb_valid_2),
    .cdb_preg_0(cdb_preg_0), .cdb_preg_1(cdb_preg_1), .cdb_preg_2(cdb_preg_2),
    .fu_ready_0(fu_ready_0), .fu_ready_1(fu_ready_1), .fu_ready_2(fu_ready_2),
    .issue_valid_0(issue_valid_0), .issue_valid_1(issue_valid_1),
    .issue_valid_2(issue_valid_2),
    .issue_idx_0(issue_idx_0), .issue_idx_1(issue_idx_1), .issue_idx_2(issue_idx_2),
    .rs_free(rs_free), .free_count(free_count), .alloc_err(alloc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid [16];
  int m_fu    [16];
  int m_ps1   [16];
  int m_ps2   [16];
  bit m_r1    [16];
  bit m_r2    [16];
  int m_stamp [16];
  int m_seq;
  bit m_err;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_stamp[i] = 0;
    end
    m_seq = 0;
    m_err = 0;
  endfunction

  // Oldest ready entry for FU k, or none.
  function automatic void m_select(input int k, output bit v, output int idx);
    v = 0; idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_r1[i] && m_r2[i] && m_fu[i] == k) begin
        if (!v || m_stamp[i] < m_stamp[idx]) begin
          v = 1; idx = i;
        end
      end
    end
  endfunction

  function automatic bit m_hit(input int tag);
    return (cdb_valid_0 && int'(cdb_preg_0) == tag) ||
           (cdb_valid_1 && int'(cdb_preg_1) == tag) ||
           (cdb_valid_2 && int'(cdb_preg_2) == tag);
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void m_step();
    bit l1, l2, sv;
    int si;
    bit xfer [16];
    bit frdy [3];
    frdy[0] = fu_ready_0; frdy[1] = fu_ready_1; frdy[2] = fu_ready_2;
    l1 = alloc_valid_1 && !m_valid[alloc_idx_1] && alloc_fu_1 != 2'd3;
    l2 = alloc_valid_2 && !m_valid[alloc_idx_2] && alloc_fu_2 != 2'd3 &&
         !(alloc_valid_1 && alloc_idx_2 == alloc_idx_1);
    if ((alloc_valid_1 && !l1) || (alloc_valid_2 && !l2)) m_err = 1;
    if (flush) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 16; i++) xfer[i] = 0;
    for (int k = 0; k < 3; k++) begin
      m_select(k, sv, si);
      if (sv && frdy[k]) xfer[si] = 1;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i]) begin
        if (m_hit(m_ps1[i])) m_r1[i] = 1;
        if (m_hit(m_ps2[i])) m_r2[i] = 1;
      end
      if (xfer[i]) m_valid[i] = 0;
    end
    if (l1) begin
      m_valid[alloc_idx_1] = 1; m_fu[alloc_idx_1] = alloc_fu_1;
      m_ps1[alloc_idx_1] = alloc_ps1_1; m_ps2[alloc_idx_1] = alloc_ps2_1;
      m_r1[alloc_idx_1] = alloc_rdy1_1 || m_hit(alloc_ps1_1);
      m_r2[alloc_idx_1] = alloc_rdy2_1 || m_hit(alloc_ps2_1);
      m_stamp[alloc_idx_1] = m_seq++;
    end
    if (l2) begin
      m_valid[alloc_idx_2] = 1; m_fu[alloc_idx_2] = alloc_fu_2;
      m_ps1[alloc_idx_2] = alloc_ps1_2; m_ps2[alloc_idx_2] = alloc_ps2_2;
      m_r1[alloc_idx_2] = alloc_rdy1_2 || m_hit(alloc_ps1_2);
      m_r2[alloc_idx_2] = alloc_rdy2_2 || m_hit(alloc_ps2_2);
      m_stamp[alloc_idx_2] = m_seq++;
    end
  endfunction

  task automatic check_all();
    bit v; int idx; logic [15:0] ef; int ec;
    m_select(0, v, idx);
    check("iv0", issue_valid_0, v); check("ix0", issue_idx_0, idx);
    m_select(1, v, idx);
    check("iv1", issue_valid_1, v); check("ix1", issue_idx_1, idx);
    m_select(2, v, idx);
    check("iv2", issue_valid_2, v); check("ix2", issue_idx_2, idx);
    ec = 0;
    for (int i = 0; i < 16; i++) begin
      ef[i] = !m_valid[i];
      ec += int'(!m_valid[i]);
    end
    check("rs_free", rs_free, ef);
    check("free_count", free_count, ec);
    check("alloc_err", alloc_err, m_err);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    flush = 0;
    alloc_valid_1 = 0; alloc_valid_2 = 0; alloc_idx_1 = 0; alloc_idx_2 = 0;
    alloc_fu_1 = 0; alloc_fu_2 = 0;
    alloc_ps1_1 = 0; alloc_ps2_1 = 0; alloc_ps1_2 = 0; alloc_ps2_2 = 0;
    alloc_rdy1_1 = 0; alloc_rdy2_1 = 0; alloc_rdy1_2 = 0; alloc_rdy2_2 = 0;
    cdb_valid_0 = 0; cdb_valid_1 = 0; cdb_valid_2 = 0;
    cdb_preg_0 = 0; cdb_preg_1 = 0; cdb_preg_2 = 0;
    fu_ready_0 = 0; fu_ready_1 = 0; fu_ready_2 = 0;
  endtask

  task automatic slot1(input int idx, input int fu, input int p1, input int p2,
                       input bit r1, input bit r2);
    alloc_valid_1 = 1; alloc_idx_1 = 4'(idx); alloc_fu_1 = 2'(fu);
    alloc_ps1_1 = 6'(p1); alloc_ps2_1 = 6'(p2); alloc_rdy1_1 = r1; alloc_rdy2_1 = r2;
  endtask

  task automatic slot2(input int idx, input int fu, input int p1, input int p2,
                       input bit r1, input bit r2);
    alloc_valid_2 = 1; alloc_idx_2 = 4'(idx); alloc_fu_2 = 2'(fu);
    alloc_ps1_2 = 6'(p1); alloc_ps2_2 = 6'(p2); alloc_rdy1_2 = r1; alloc_rdy2_2 = r2;
  endtask

  // One clock: model follows the driven inputs, then compare at the falling edge.
  task automatic tick();
    m_step();
    @(negedge clk);
    check_all();
  endtask

  // Mostly a free index (per the model), sometimes any index.
  function automatic int pick_idx();
    int s;
    s = $urandom_range(15);
    if ($urandom_range(7) != 0) begin
      for (int n = 0; n < 16; n++) begin
        if (!m_valid[(s + n) % 16]) return (s + n) % 16;
      end
    end
    return s;
  endfunction

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_iv0", issue_valid_0, 0);
    check("rst_ix0", issue_idx_0, 0);
    check("rst_free", rs_free, 16'hFFFF);
    check("rst_cnt", free_count, 16);
    check("rst_err", alloc_err, 0);
    rst_n = 1;
    @(negedge clk);
    check_all();

    // Single ready allocation issues next cycle and frees on handshake.
    slot1(3, 0, 1, 2, 1, 1);
    tick();
    check("t1_iv0", issue_valid_0, 1);
    check("t1_ix0", issue_idx_0, 3);
    idle(); fu_ready_0 = 1;
    tick();
    check("t1_free3", rs_free[3], 1);
    check("t1_cnt", free_count, 16);

    // Wakeup through the FU2 broadcast.
    idle(); slot1(5, 1, 12, 20, 0, 1);
    tick();
    idle(); slot1(2, 1, 21, 22, 1, 1);
    tick();
    check("t2_ix1_first", issue_idx_1, 2);
    idle(); cdb_valid_2 = 1; cdb_preg_2 = 12; fu_ready_1 = 1;
    tick();
    check("t2_iv1_woken", issue_valid_1, 1);
    check("t2_ix1_woken", issue_idx_1, 5);
    idle(); fu_ready_1 = 1;
    tick();
    check("t2_iv1_empty", issue_valid_1, 0);

    // Same-cycle age order: slot 1 older than slot 2.
    idle(); slot1(9, 0, 1, 1, 1, 1); slot2(1, 0, 1, 1, 1, 1);
    tick();
    check("t3_ix0_old", issue_idx_0, 9);
    idle();
    tick();
    check("t3_ix0_hold", issue_idx_0, 9);
    idle(); fu_ready_0 = 1;
    tick();
    check("t3_ix0_young", issue_idx_0, 1);
    idle(); fu_ready_0 = 1;
    tick();

    // Three transfers in one cycle.
    idle(); slot1(4, 0, 3, 3, 1, 1); slot2(6, 1, 3, 3, 1, 1);
    tick();
    idle(); slot1(7, 2, 3, 3, 1, 1);
    tick();
    check("t4_cnt13", free_count, 13);
    idle(); fu_ready_0 = 1; fu_ready_1 = 1; fu_ready_2 = 1;
    tick();
    check("t4_cnt16", free_count, 16);

    // Fill every entry, then over-allocate.
    for (int c = 0; c < 8; c++) begin
      idle(); slot1(2*c, c % 3, 40, 41, 0, 0); slot2(2*c+1, (c+1) % 3, 42, 43, 0, 0);
      tick();
    end
    check("t5_full", free_count, 0);
    check("t5_err0", alloc_err, 0);
    idle(); slot1(0, 0, 1, 1, 1, 1);
    tick();
    check("t5_err1", alloc_err, 1);
    idle(); flush = 1;
    tick();
    check("t5_err_sticky", alloc_err, 1);

    // Flush with six valid entries and a concurrent allocation.
    for (int c = 0; c < 3; c++) begin
      idle(); slot1(2*c, c, 5, 5, 1, 1); slot2(2*c+1, (c+1) % 3, 5, 5, 1, 1);
      tick();
    end
    check("t6_cnt10", free_count, 10);
    idle(); flush = 1; slot1(10, 0, 5, 5, 1, 1);
    tick();
    check("t6_free", rs_free, 16'hFFFF);
    check("t6_iv_any", {issue_valid_2, issue_valid_1, issue_valid_0}, 0);

    // Asynchronous reset in the middle of a handshake.
    idle(); slot1(3, 0, 5, 5, 1, 1); slot2(8, 1, 5, 5, 1, 1);
    tick();
    idle(); fu_ready_0 = 1; fu_ready_1 = 1;
    #2 rst_n = 0;
    #1;
    check("t7_iv0", issue_valid_0, 0);
    check("t7_iv1", issue_valid_1, 0);
    check("t7_ix1", issue_idx_1, 0);
    check("t7_free", rs_free, 16'hFFFF);
    check("t7_cnt", free_count, 16);
    check("t7_err", alloc_err, 0);
    m_reset();
    idle();
    @(negedge clk);
    rst_n = 1;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      idle();
      flush = ($urandom_range(63) == 0);
      if ($urandom_range(9) < 6)
        slot1(pick_idx(), ($urandom_range(15) == 0) ? 3 : $urandom_range(2),
              $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(9) < 6)
        slot2(pick_idx(), ($urandom_range(15) == 0) ? 3 : $urandom_range(2),
              $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)), 1'($urandom_range(1)));
      cdb_valid_0 = 1'($urandom_range(1)); cdb_preg_0 = 6'($urandom_range(7));
      cdb_valid_1 = 1'($urandom_range(1)); cdb_preg_1 = 6'($urandom_range(7));
      cdb_valid_2 = 1'($urandom_range(1)); cdb_preg_2 = 6'($urandom_range(7));
      fu_ready_0 = ($urandom_range(3) != 0);
      fu_ready_1 = ($urandom_range(3) != 0);
      fu_ready_2 = ($urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
